cycle_sequencer: RTL and testbench

Instruction-cycle sequencer for the PIC core. It divides the system clock into the four-phase instruction cycle (clk1..clk4 phase strobes) that drives the program counter, decode, ALU, W register and RAM. It also decides per cycle whether the datapath executes or runs a flush (NOP) cycle after a taken branch. It adds sleep/wake and a hold (stall) between instruction cycles, plus a free-running instruction-cycle counter.

---
 rtl/cycle_sequencer.sv | 92 +++++++++
 tb/tb_cycle_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// Four-phase instruction-cycle sequencer: phase strobes clk1..clk4, execute/flush
// decision per cycle, sleep/wake, inter-cycle hold and an instruction-cycle counter.
module cycle_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch,
  input  logic             sleep_req,
  input  logic             wake,
  input  logic             hold,
  output logic             clk1,
  output logic             clk2,
  output logic             clk3,
  output logic             clk4,
  output logic             exec_en,
  output logic             sleeping,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_SLEEP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             boundary;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FLUSH;
      phase_q  <= 2'd0;
      active_q <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      active_q <= active_d;
      icount_q <= icount_d;
    end
  end

  // A boundary is the edge on which the Q4 strobe is currently high.
  assign boundary = active_q && (phase_q == 2'd3);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    active_d = active_q;
    icount_d = icount_q;
    if (state_q == ST_SLEEP) begin
      // Wake leaves SLEEP even under hold; hold then only delays the Q1 strobe.
      if (wake) begin
        state_d  = ST_RUN;
        phase_d  = 2'd0;
        active_d = !hold;
      end
    end else if (!active_q) begin
      // Idle slot (after reset or during hold): Q1 is pending.
      if (!hold) begin
        active_d = 1'b1;
        phase_d  = 2'd0;
      end
    end else if (boundary) begin
      icount_d = icount_q + CNT_W'(1);
      phase_d  = 2'd0;
      case (state_q)
        ST_RUN: begin
          if (branch)         state_d = ST_FLUSH;
          else if (sleep_req) state_d = ST_SLEEP;
        end
        default: state_d = ST_RUN;
      endcase
      active_d = (state_d != ST_SLEEP) && !hold;
    end else begin
      phase_d = phase_q + 2'd1;
    end
  end

  assign clk1     = active_q && (phase_q == 2'd0);
  assign clk2     = active_q && (phase_q == 2'd1);
  assign clk3     = active_q && (phase_q == 2'd2);
  assign clk4     = active_q && (phase_q == 2'd3);
  assign exec_en  = (state_q == ST_RUN);
  assign sleeping = (state_q == ST_SLEEP);
  assign icount   = icount_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed per-edge vectors feed an expected queue,
// a monitor compares DUT outputs one time unit after every rising edge.
module tb_cycle_sequencer;

  localparam int CNT_W = 16;
  localparam int W     = 4 + 1 + 1 + CNT_W;

  localparam logic [3:0] S0 = 4'b0000;
  localparam logic [3:0] S1 = 4'b0001;
  localparam logic [3:0] S2 = 4'b0010;
  localparam logic [3:0] S3 = 4'b0100;
  localparam logic [3:0] S4 = 4'b1000;

  logic             clk = 1'b0;
  logic             reset;
  logic             branch, sleep_req, wake, hold;
  logic             clk1, clk2, clk3, clk4, exec_en, sleeping;
  logic [CNT_W-1:0] icount;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           passed = 0;
  int           vec_idx = 0;

  cycle_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .branch    (branch),
    .sleep_req (sleep_req),
    .wake      (wake),
    .hold      (hold),
    .clk1      (clk1),
    .clk2      (clk2),
    .clk3      (clk3),
    .clk4      (clk4),
    .exec_en   (exec_en),
    .sleeping  (sleeping),
    .icount    (icount)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] dut_vec();
    return {clk4, clk3, clk2, clk1, exec_en, sleeping, icount};
  endfunction

  // Driver: inputs for the coming rising edge and the outputs expected after it.
  task automatic cyc(input logic b, input logic s, input logic w, input logic h,
                     input logic [3:0] st, input logic ex, input logic sl,
                     input logic [CNT_W-1:0] ic);
    @(negedge clk);
    branch    = b;
    sleep_req = s;
    wake      = w;
    hold      = h;
    exp_q.push_back({st, ex, sl, ic});
  endtask

  // One full instruction cycle with idle inputs, starting at clk1.
  task automatic quad(input logic ex, input logic [CNT_W-1:0] ic);
    cyc(0, 0, 0, 0, S1, ex, 1'b0, ic);
    cyc(0, 0, 0, 0, S2, ex, 1'b0, ic);
    cyc(0, 0, 0, 0, S3, ex, 1'b0, ic);
    cyc(0, 0, 0, 0, S4, ex, 1'b0, ic);
  endtask

  task automatic chk_now(input string name, input logic [W-1:0] exp);
    logic [W-1:0] got;
    got = dut_vec();
    checks++;
    if (got !== exp)
      $display("FAIL %s: got strb=%b ex=%b sl=%b ic=%0d, want strb=%b ex=%b sl=%b ic=%0d",
               name, got[W-1 -: 4], got[CNT_W+1], got[CNT_W], got[CNT_W-1:0],
               exp[W-1 -: 4], exp[CNT_W+1], exp[CNT_W], exp[CNT_W-1:0]);
    else
      passed++;
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      chk_now($sformatf("edge_vec[%0d]", vec_idx), exp_q.pop_front());
      vec_idx++;
    end
  end

  initial begin
    reset = 1'b0; branch = 1'b0; sleep_req = 1'b0; wake = 1'b0; hold = 1'b0;
    #3;
    chk_now("reset_state", '0);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;

    // Power-up: FLUSH prime cycle, then RUN.
    quad(1'b0, 16'd0);
    quad(1'b1, 16'd1);
    quad(1'b1, 16'd2);

    // Taken branch at a RUN clk4 -> one flush cycle.
    cyc(1, 0, 0, 0, S1, 1'b0, 1'b0, 16'd3);
    cyc(0, 0, 0, 0, S2, 1'b0, 1'b0, 16'd3);
    cyc(0, 0, 0, 0, S3, 1'b0, 1'b0, 16'd3);
    cyc(0, 0, 0, 0, S4, 1'b0, 1'b0, 16'd3);
    cyc(0, 0, 0, 0, S1, 1'b1, 1'b0, 16'd4);
    // branch away from clk4 is not sampled
    cyc(1, 1, 0, 0, S2, 1'b1, 1'b0, 16'd4);
    cyc(0, 0, 0, 0, S3, 1'b1, 1'b0, 16'd4);
    cyc(0, 0, 0, 0, S4, 1'b1, 1'b0, 16'd4);

    // SLEEP for ten edges, ignoring hold and branch, then a wake pulse.
    cyc(0, 1, 0, 0, S0, 1'b0, 1'b1, 16'd5);
    for (int i = 0; i < 10; i++)
      cyc(i == 3, 0, 0, i == 5, S0, 1'b0, 1'b1, 16'd5);
    cyc(0, 0, 1, 0, S1, 1'b1, 1'b0, 16'd5);
    cyc(0, 0, 0, 0, S2, 1'b1, 1'b0, 16'd5);
    cyc(0, 0, 0, 0, S3, 1'b1, 1'b0, 16'd5);
    cyc(0, 0, 0, 0, S4, 1'b1, 1'b0, 16'd5);

    // Hold for three edges from a boundary: three idle slots.
    cyc(0, 0, 0, 1, S0, 1'b1, 1'b0, 16'd6);
    cyc(0, 0, 0, 1, S0, 1'b1, 1'b0, 16'd6);
    cyc(0, 0, 0, 1, S0, 1'b1, 1'b0, 16'd6);
    cyc(0, 0, 0, 0, S1, 1'b1, 1'b0, 16'd6);
    cyc(0, 0, 0, 1, S2, 1'b1, 1'b0, 16'd6);
    cyc(0, 0, 0, 1, S3, 1'b1, 1'b0, 16'd6);
    cyc(0, 0, 0, 0, S4, 1'b1, 1'b0, 16'd6);

    // branch and sleep_req together: branch wins.
    cyc(0, 0, 0, 0, S1, 1'b1, 1'b0, 16'd7);
    cyc(0, 0, 0, 0, S2, 1'b1, 1'b0, 16'd7);
    cyc(0, 0, 0, 0, S3, 1'b1, 1'b0, 16'd7);
    cyc(0, 0, 0, 0, S4, 1'b1, 1'b0, 16'd7);
    cyc(1, 1, 0, 0, S1, 1'b0, 1'b0, 16'd8);
    cyc(0, 1, 0, 0, S2, 1'b0, 1'b0, 16'd8);
    cyc(0, 0, 0, 0, S3, 1'b0, 1'b0, 16'd8);
    cyc(1, 1, 0, 0, S4, 1'b0, 1'b0, 16'd8);
    cyc(0, 0, 0, 0, S1, 1'b1, 1'b0, 16'd9);
    cyc(0, 0, 0, 0, S2, 1'b1, 1'b0, 16'd9);
    cyc(0, 0, 0, 0, S3, 1'b1, 1'b0, 16'd9);

    // Asynchronous reset in the middle of clk3.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_now("async_reset_midcycle", '0);
    @(posedge clk);
    #2;
    chk_now("held_in_reset", '0);
    reset = 1'b1;
    quad(1'b0, 16'd0);
    cyc(0, 0, 0, 0, S1, 1'b1, 1'b0, 16'd1);
    cyc(0, 0, 0, 0, S2, 1'b1, 1'b0, 16'd1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL queue_drain: %0d expected vectors left, want 0", exp_q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
